mmio_timer_periph: RTL and testbench
====================================

Name: mmio_timer_periph

Overview:
Memory-mapped peripheral block downstream of the pipeline's MEM stage. It receives the same address, write data, read and write strobes that the CPU drives into data memory, and decodes a 32-byte window at BASE_ADDR. The window holds a reloadable interval timer with interrupt, a free-running systick counter, an LED register and a seven-segment digit register. The top-level data-memory read mux selects rdata whenever hit is high.

Parameters:
BASE_ADDR, 32'h4000_0000, byte address of the register window; must be 32-byte aligned.

Ports:
clk  input  1  system clock (the divided CPU clock); all state updates on rising edge
reset  input  1  asynchronous, active-low reset
addr  input  32  byte address from the MEM stage (ALU result)
wdata  input  32  store data from the MEM stage
mem_read  input  1  load strobe
mem_write  input  1  store strobe
hit  output  1  addr falls in the window, i.e. addr[31:5] == BASE_ADDR[31:5]
rdata  output  32  read data, combinational
irq  output  1  timer interrupt request
leds  output  8  LED register bits [7:0]
bcd7  output  8  segment lines, DIGI[7:0]
an  output  4  digit enables, DIGI[11:8]

Behaviour:
- Register map (offset, name, access):
  - 0x00 TH: RW, reload value.
  - 0x04 TL: RW, counter.
  - 0x08 TCON: RW bits[2:0]; upper bits read as 0.
  - 0x0C LED: RW bits[7:0].
  - 0x10 DIGI: RW bits[11:0].
  - 0x14 SYSTICK: RO.
  - Offsets 0x18 and 0x1C: reads return 0, writes are ignored.
- Decode uses addr[4:2] only. addr[1:0] is ignored, so all accesses are word accesses.
- Reset (reset==0, asynchronous): TH, TL, TCON, LED, DIGI and SYSTICK all clear to 0. Outputs are then irq=0, leds=0, bcd7=0, an=0. Reset takes effect immediately, including in the middle of a count.
- Reads:
  - rdata = selected register when hit && mem_read; otherwise 0.
  - Reads are zero-latency and combinational, matching the data-memory read timing.
  - Reads have no side effects.
- Writes:
  - Occur on the rising clk edge when hit && mem_write.
  - Only defined bits are stored; undefined bits are dropped.
  - A write to SYSTICK is ignored.
- TCON bits:
  - bit0: timer enable.
  - bit1: interrupt enable.
  - bit2: interrupt status. Set only by hardware; software clears it by writing 0.
- Timer, evaluated each edge while TCON[0]=1:
  - If TL==32'hFFFF_FFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
  - Otherwise TL<=TL+1.
  - While TCON[0]=0, TL holds its value.
- irq = TCON[1] & TCON[2], registered-state derived with no extra delay.
- SYSTICK increments by 1 on every edge, independent of TCON, and wraps from 32'hFFFF_FFFF to 0.
- Simultaneous events on the same edge:
  - Software write to TL beats a hardware increment or reload; the written value is stored.
  - Software write to TH with a reload on the same edge: the reload uses the old TH; the new TH is stored.
  - Software write to TCON with an overflow on the same edge: bits[1:0] take the written value. bit2 = 1 if the overflow sets it (evaluated with the old TCON[1]); otherwise bit2 takes the written bit2. Hardware set wins over software clear, so no interrupt is lost.
  - Writing TCON[0]=0 on the overflow edge still completes that reload.
- Address outside the window: hit=0, no state change, rdata=0.
- No handshake and no wait states; every access completes in its MEM cycle.

Test Plan:
1. Assert reset low mid-run with TL=0x1234 and LED=0xA5 -> all registers read 0 immediately; irq=0, leds=0, an=0, bcd7=0.
2. Write TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, then TCON=3 -> TL reads 0xFFFF_FFFF one edge later. On the next edge TL=0xFFFF_FFF0, TCON=7 and irq=1; 16 edges after that a second overflow occurs.
3. With TCON=3, write TCON=1 (clear status, disable irq) -> irq falls the same edge. Then write TCON=3 on the exact overflow edge -> TCON reads 7 and irq stays 1 (hardware set wins).
4. Store 0x5A to 0x4000_000C and 0x0E3F to 0x4000_0010 -> leds=0x5A, an=0xE, bcd7=0x3F. A load from 0x4000_0010 returns 0x0000_0E3F.
5. Write TL=0x100 on the same edge as an enabled increment -> TL reads 0x100. Write to SYSTICK -> the value is unchanged and the counter keeps incrementing by 1 per edge.
6. Load from 0x4000_0018 and from 0x0000_0010 -> first: hit=1, rdata=0. Second: hit=0, rdata=0. A store to 0x0000_0008 leaves TCON unchanged.

Source files
------------

// File: rtl/mmio_timer_periph.sv
// MMIO window with interval timer, systick, LED and digit registers.
// Ports: clk, reset (async low), addr/wdata/mem_read/mem_write in; hit/rdata/irq/leds/bcd7/an out.
module mmio_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [7:0]  bcd7,
  output logic [3:0]  an
);

  localparam logic [2:0] R_TH   = 3'd0;
  localparam logic [2:0] R_TL   = 3'd1;
  localparam logic [2:0] R_TCON = 3'd2;
  localparam logic [2:0] R_LED  = 3'd3;
  localparam logic [2:0] R_DIGI = 3'd4;
  localparam logic [2:0] R_TICK = 3'd5;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [31:0] systick;

  logic [2:0] sel;
  logic       wr;
  logic       ovf;
  logic       set_st;
  logic       unused_ok;

  assign hit       = addr[31:5] == BASE_ADDR[31:5];
  assign sel       = addr[4:2];
  assign wr        = hit && mem_write;
  assign unused_ok = ^addr[1:0];

  // Overflow and status set both use the pre-edge TCON.
  assign ovf    = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign set_st = ovf && tcon[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr && sel == R_TH)
        th <= wdata;
      if (wr && sel == R_TL)
        tl <= wdata;
      else if (ovf)
        tl <= th;
      else if (tcon[0])
        tl <= tl + 32'd1;
      // Hardware set wins over a software clear.
      if (wr && sel == R_TCON)
        tcon <= {wdata[2] | set_st, wdata[1:0]};
      else if (set_st)
        tcon[2] <= 1'b1;
      if (wr && sel == R_LED)
        led <= wdata[7:0];
      if (wr && sel == R_DIGI)
        digi <= wdata[11:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && mem_read) begin
      unique case (sel)
        R_TH:    rdata = th;
        R_TL:    rdata = tl;
        R_TCON:  rdata = {29'd0, tcon};
        R_LED:   rdata = {24'd0, led};
        R_DIGI:  rdata = {20'd0, digi};
        R_TICK:  rdata = systick;
        default: rdata = '0;
      endcase
    end
  end

  assign irq  = tcon[1] & tcon[2];
  assign leds = led;
  assign bcd7 = digi[7:0];
  assign an   = digi[11:8];

endmodule

// File: tb/tb_mmio_timer_periph.sv
// Directed self-checking bench for mmio_timer_periph.
// Drives MEM-stage style loads/stores and checks registers and outputs.
module tb_mmio_timer_periph;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  leds;
  logic [7:0]  bcd7;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] B     = 32'h4000_0000;
  localparam logic [31:0] A_TH  = B + 32'h00;
  localparam logic [31:0] A_TL  = B + 32'h04;
  localparam logic [31:0] A_TC  = B + 32'h08;
  localparam logic [31:0] A_LED = B + 32'h0C;
  localparam logic [31:0] A_DG  = B + 32'h10;
  localparam logic [31:0] A_ST  = B + 32'h14;

  mmio_timer_periph #(.BASE_ADDR(B)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .hit(hit),
    .rdata(rdata),
    .irq(irq),
    .leds(leds),
    .bcd7(bcd7),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    addr      = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d        = rdata;
    mem_read = 1'b0;
    addr     = 32'h0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  logic [31:0] s0;
  logic [31:0] s1;

  initial begin
    reset     = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (2) tick();
    reset = 1'b1;

    // Reset mid-run
    wr(A_TL, 32'h0000_1234);
    wr(A_LED, 32'h0000_00A5);
    wr(A_DG, 32'h0000_0E3F);
    wr(A_TH, 32'h0000_0055);
    rdchk("tl_pre", A_TL, 32'h0000_1234);
    chk("leds_pre", {24'd0, leds}, 32'h0000_00A5);
    wr(A_TC, 32'h0000_0001);
    tick();
    reset = 1'b0;
    rdchk("rst_th", A_TH, 32'h0);
    rdchk("rst_tl", A_TL, 32'h0);
    rdchk("rst_tc", A_TC, 32'h0);
    rdchk("rst_led", A_LED, 32'h0);
    rdchk("rst_dg", A_DG, 32'h0);
    rdchk("rst_st", A_ST, 32'h0);
    chk("rst_out", {19'd0, irq, leds, an},
        32'h0);
    chk("rst_bcd7", {24'd0, bcd7}, 32'h0);
    tick();
    reset = 1'b1;

    // Reload and interrupt
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h0000_0003);
    rdchk("tl_hold", A_TL, 32'hFFFF_FFFE);
    tick();
    rdchk("tl_ff", A_TL, 32'hFFFF_FFFF);
    tick();
    rdchk("tl_rel1", A_TL, 32'hFFFF_FFF0);
    rdchk("tc_ovf1", A_TC, 32'h0000_0007);
    chk("irq_ovf1", {31'd0, irq}, 32'h1);
    wr(A_TC, 32'h0000_0003);
    chk("irq_clr", {31'd0, irq}, 32'h0);
    repeat (14) tick();
    rdchk("tl_ff2", A_TL, 32'hFFFF_FFFF);
    rdchk("tc_pre2", A_TC, 32'h0000_0003);
    tick();
    rdchk("tl_rel2", A_TL, 32'hFFFF_FFF0);
    rdchk("tc_ovf2", A_TC, 32'h0000_0007);

    // Software clear vs hardware set
    wr(A_TC, 32'h0000_0001);
    chk("irq_fall", {31'd0, irq}, 32'h0);
    rdchk("tc_1", A_TC, 32'h0000_0001);
    wr(A_TC, 32'h0000_0003);
    repeat (13) tick();
    rdchk("tl_ff3", A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h0000_0003);
    rdchk("tc_hwwin", A_TC, 32'h0000_0007);
    chk("irq_hwwin", {31'd0, irq}, 32'h1);
    rdchk("tl_rel3", A_TL, 32'hFFFF_FFF0);
    wr(A_TC, 32'h0000_0000);
    rdchk("tc_off", A_TC, 32'h0);
    tick();
    rdchk("tl_frozen", A_TL, 32'hFFFF_FFF1);

    // LED and digits, undefined bits dropped
    wr(A_LED, 32'hFFFF_FF5A);
    wr(A_DG, 32'hFFFF_FE3F);
    chk("leds", {24'd0, leds}, 32'h0000_005A);
    chk("an", {28'd0, an}, 32'h0000_000E);
    chk("bcd7", {24'd0, bcd7}, 32'h0000_003F);
    rdchk("rd_led", A_LED, 32'h0000_005A);
    rdchk("rd_dg", A_DG, 32'h0000_0E3F);
    wr(A_TC, 32'hFFFF_FFF8);
    rdchk("tc_mask", A_TC, 32'h0000_0000);

    // TL write beats increment; SYSTICK read-only
    wr(A_TC, 32'h0000_0001);
    wr(A_TL, 32'h0000_0100);
    rdchk("tl_wr", A_TL, 32'h0000_0100);
    tick();
    rdchk("tl_inc", A_TL, 32'h0000_0101);
    rd(A_ST, s0);
    wr(A_ST, 32'hDEAD_0000);
    rd(A_ST, s1);
    chk("st_ro", s1, s0 + 32'd1);
    tick();
    rd(A_ST, s1);
    chk("st_inc", s1, s0 + 32'd2);

    // Unmapped and out-of-window accesses
    addr = B + 32'h18;
    mem_read = 1'b1;
    #1;
    chk("hit_18", {31'd0, hit}, 32'h1);
    chk("rd_18", rdata, 32'h0);
    addr = 32'h0000_0010;
    #1;
    chk("hit_out", {31'd0, hit}, 32'h0);
    chk("rd_out", rdata, 32'h0);
    mem_read = 1'b0;
    addr = A_LED;
    #1;
    chk("rd_noread", rdata, 32'h0);
    wr(32'h0000_0008, 32'h0000_0000);
    rdchk("tc_outwr", A_TC, 32'h0000_0001);
    wr(B + 32'h1C, 32'hFFFF_FFFF);
    rdchk("rd_1c", B + 32'h1C, 32'h0);

    // Disabling on the overflow edge still reloads
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h0000_0000);
    rdchk("tl_dis_rel", A_TL, 32'hFFFF_FFF0);
    rdchk("tc_dis", A_TC, 32'h0);
    tick();
    rdchk("tl_dis_hold", A_TL, 32'hFFFF_FFF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
